muldiv_seq_unit: RTL
====================

Name: muldiv_seq_unit

Overview:
Sequential, parametrised RISC-V M-extension execute unit. It replaces the single-cycle combinational multiply/divide ALU.
- Handles all eight M-extension ops for XLEN-bit operands.
- Multiply: a 2-cycle registered path. Divide/remainder: a radix-2 restoring iterative divider.
- Sits beside the integer ALU in the execute stage, with valid/ready handshakes on both sides, a result tag and a flush input.

Parameters:
XLEN, 32, operand/result width (>=8, even)
TAG_W, 5, width of destination tag carried with each operation

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of any in-flight op
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request (high only in IDLE)
funct3  input  3  RV M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  XLEN  operand A (dividend)
rs2  input  XLEN  operand B (divisor)
in_tag  input  TAG_W  tag to echo with the result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  result
out_tag  output  TAG_W  echoed tag
div_by_zero  output  1  op was DIV/DIVU/REM/REMU with rs2==0; qualified by out_valid
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - result, out_tag, div_by_zero all 0.
  - Reset mid-operation discards the op with no output.
- FSM states: IDLE, MUL, DIV, FIX, DONE. Edge 0 is the accept edge (in_valid & in_ready sampled high). At accept, funct3, operands and in_tag are captured.
- IDLE:
  - funct3[2]=0 -> MUL.
  - funct3[2]=1 with rs2==0 -> DONE, special result.
  - DIV/REM with rs1=most-negative and rs2=all-ones -> DONE, overflow result.
  - Otherwise -> DIV: |rs1| and |rs2| (or raw values for unsigned ops) captured, counter=XLEN.
- MUL:
  - 2*XLEN product formed; signedness per op (MULHSU: rs1 signed, rs2 unsigned).
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
  - Goes to DONE; out_valid high after edge 1.
- DIV:
  - One quotient bit per edge, MSB first (restoring), counter decrements; XLEN edges (edges 1..XLEN), then FIX.
- FIX (edge XLEN+1):
  - Signed ops: quotient negated when the operand signs differ; remainder takes the dividend's sign.
  - Goes to DONE; out_valid high after edge XLEN+1.
- Special results (latency: out_valid after edge 1):
  - Div-by-zero: DIV/DIVU -> all ones; REM/REMU -> rs1; div_by_zero=1.
  - Overflow: DIV -> most-negative; REM -> 0; div_by_zero=0.
- DONE:
  - out_valid=1; result, out_tag and div_by_zero held stable while out_ready=0.
  - out_valid & out_ready -> IDLE next edge, out_valid=0.
  - No new accept in the same cycle (in_ready=0 outside IDLE).
- flush (synchronous, highest priority after reset):
  - At the next edge state=IDLE, out_valid=0, the in-flight op and any pending result are dropped.
  - flush in IDLE blocks accept that cycle.
- div_by_zero is 0 for all multiply ops.
- Throughput: one op at a time; no overlap.

Test Plan:
1. MUL, rs1=10, rs2=20, in_tag=7 -> result=200, out_tag=7, out_valid after edge 1; MUL rs1=-10, rs2=5 -> 0xFFFFFFCE.
2. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH -1 x -1 -> 0; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV -100/7 -> 0xFFFFFFF2 (-14), REM -100/7 -> 0xFFFFFFFE (-2); DIVU 100/3 -> 33, REMU 35/4 -> 3; out_valid after edge 33; in_ready=0, busy=1 throughout.
4. DIVU 100/0 -> 0xFFFFFFFF, div_by_zero=1; REM 35/0 -> 35, div_by_zero=1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same operands -> 0, div_by_zero=0; all with out_valid after edge 1.
5. Backpressure: out_ready low 5 cycles in DONE -> out_valid, result and out_tag held constant, in_ready=0; out_ready high -> IDLE next edge, a new op is accepted.
6. flush asserted at edge 10 of a DIV -> IDLE at the next edge, out_valid never rises; rst_n pulsed low mid-DIV -> all outputs at reset values immediately; following MUL 3x4 -> 12.

Source files
------------

// File: rtl/muldiv_seq_unit_if.sv
// Request/response bus of the sequential M-extension unit.
// master = issuing pipeline side, slave = muldiv_seq_unit.
interface muldiv_seq_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output flush, in_valid, funct3, rs1, rs2, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, div_by_zero, busy
  );

  modport slave (
    input  flush, in_valid, funct3, rs1, rs2, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, div_by_zero, busy
  );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Sequential RISC-V M-extension execute unit: 2-cycle multiply,
// radix-2 restoring divider, one operation in flight at a time.
module muldiv_seq_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_seq_unit_if.slave   bus
);
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q;        // funct3[1:0]; funct3[2] is implied by the path taken
  logic [TAG_W-1:0]  tag_q;
  logic [XLEN-1:0]   a_q;         // mul operand A / dividend-quotient shift register / special value
  logic [XLEN-1:0]  b_q;          // mul operand B / divisor magnitude
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   res_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_quo_q, neg_rem_q, special_q, dbz_q;

  // Request decode
  logic            accept, is_div, div_signed, divz, ovf, special;
  logic            rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_abs, rs2_abs, spec_val;

  assign accept     = bus.in_valid & (state_q == S_IDLE) & ~bus.flush;
  assign is_div     = bus.funct3[2];
  assign div_signed = ~bus.funct3[0];
  assign divz       = (bus.rs2 == '0);
  assign ovf        = div_signed & (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.rs2);
  assign special    = divz | ovf;
  assign rs1_neg    = div_signed & bus.rs1[XLEN-1];
  assign rs2_neg    = div_signed & bus.rs2[XLEN-1];
  assign rs1_abs    = rs1_neg ? -bus.rs1 : bus.rs1;
  assign rs2_abs    = rs2_neg ? -bus.rs2 : bus.rs2;
  // Divide-by-zero: quotient all ones, remainder = dividend.
  // Overflow: quotient = most-negative (= rs1), remainder 0.
  assign spec_val   = divz ? (bus.funct3[1] ? bus.rs1 : '1)
                           : (bus.funct3[1] ? '0 : bus.rs1);

  // Multiply datapath: sign-extend per op, keep low or high half
  logic              mul_a_signed, mul_b_signed;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, product;
  logic [XLEN-1:0]   mul_res;

  assign mul_a_signed = (op_q == 2'b01) | (op_q == 2'b10);
  assign mul_b_signed = (op_q == 2'b01);
  assign mul_a_ext    = {{XLEN{mul_a_signed & a_q[XLEN-1]}}, a_q};
  assign mul_b_ext    = {{XLEN{mul_b_signed & b_q[XLEN-1]}}, b_q};
  assign product      = mul_a_ext * mul_b_ext;
  assign mul_res      = (op_q == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // Restoring divide step; trial is XLEN+1 bits since 2*rem+1 can exceed XLEN bits
  logic [XLEN:0]   shifted, diff;
  logic            take;
  logic [XLEN-1:0] rem_step, quo_step, quo_fix, rem_fix, div_res;

  assign shifted  = {rem_q, a_q[XLEN-1]};
  assign diff     = shifted - {1'b0, b_q};
  assign take     = ~diff[XLEN];
  assign rem_step = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_step = {a_q[XLEN-2:0], take};
  assign quo_fix  = neg_quo_q ? -a_q : a_q;
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;
  assign div_res  = op_q[1] ? rem_fix : quo_fix;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    // NOTE: state_d gets a default before any branch so no path can infer a latch.
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = !is_div ? S_MUL : (special ? S_FIX : S_DIV);
        S_MUL:  state_d = S_DONE;
        S_DIV:  if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (bus.out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operand capture, iteration and result registers.
  // Special cases pass through FIX so they share its one-edge result write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      tag_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here reads pre-edge values.
      case (state_q)
        S_IDLE: if (accept) begin
          op_q      <= bus.funct3[1:0];
          tag_q     <= bus.in_tag;
          a_q       <= !is_div ? bus.rs1 : (special ? spec_val : rs1_abs);
          b_q       <= is_div ? rs2_abs : bus.rs2;
          rem_q     <= '0;
          cnt_q     <= CNT_W'(XLEN);
          neg_quo_q <= rs1_neg ^ rs2_neg;
          neg_rem_q <= rs1_neg;
          special_q <= is_div & special;
        end
        S_MUL: begin
          res_q <= mul_res;
          dbz_q <= 1'b0;
        end
        S_DIV: begin
          a_q   <= quo_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: begin
          res_q <= special_q ? a_q : div_res;
          dbz_q <= special_q & (b_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.result      = res_q;
  assign bus.out_tag     = tag_q;
  assign bus.div_by_zero = dbz_q;
endmodule
